// File: rtl/sd_ctrl_pkg.sv
// Shared definitions for the SD-card image store controllers (read and write side).
// Contents:
//   sd_state_e        - one-hot sequencer states IDLE / READ / WAIT
//   IMG_SEC_ADDR0_DEF - default first sector of image slot 0
//   SEC_NUM_DEF       - default number of sectors per image
//   img_base()        - first sector of a given image slot (modulo 2^32)
package sd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_READ = 3'b010,
        ST_WAIT = 3'b100
    } sd_state_e;

    localparam logic [31:0] IMG_SEC_ADDR0_DEF = 32'd0;
    localparam logic [15:0] SEC_NUM_DEF       = 16'd1200;

    // Slot base address; the product wraps at 32 bits like the address bus does.
    function automatic logic [31:0] img_base(input logic [31:0] addr0,
                                             input logic [15:0] sec_num,
                                             input logic [31:0] sel);
        return addr0 + (sel * {16'd0, sec_num});
    endfunction

endpackage

// File: rtl/sig_edge_det.sv
// Registers a level signal and reports its rising and falling edges.
// Ports:
//   sys_clk, sys_rst_n - clock, asynchronous active-low reset
//   sig_in             - level to watch
//   rise               - high for the cycle where sig_in is 1 and was 0 last cycle
//   fall               - high for the cycle where sig_in is 0 and was 1 last cycle
module sig_edge_det (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic dly_q;
    logic dly_d;

    always_comb begin
        dly_d = sig_in;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dly_q <= 1'b0;
        end else begin
            dly_q <= dly_d;
        end
    end

    assign rise = ~dly_q & sig_in;
    assign fall = dly_q & ~sig_in;

endmodule

// File: rtl/sd_img_rd_ctrl.sv
// Read-side sequencer of the SD-card image store. On an accepted request it
// walks SEC_NUM consecutive sectors from the selected slot's base, issuing one
// single-cycle rd_en per sector and pacing on the falling edge of rd_busy.
// Ports:
//   sys_clk, sys_rst_n - 50 MHz clock, asynchronous active-low reset
//   init_end           - SD init complete (level); loss aborts a transfer
//   rd_start           - request one image readback; only seen in IDLE
//   img_sel            - image slot, used on the accepted rd_start
//   rd_busy            - SD read engine busy (level)
//   rd_en / rd_addr    - sector read request pulse and its address (held otherwise)
//   rd_active          - transfer in progress
//   rd_done / rd_err   - completion / abort pulses
module sd_img_rd_ctrl
    import sd_ctrl_pkg::*;
#(
    parameter logic [31:0] IMG_SEC_ADDR0 = IMG_SEC_ADDR0_DEF,
    parameter logic [15:0] SEC_NUM       = SEC_NUM_DEF,
    parameter int          IMG_SEL_W     = 2,
    parameter logic [15:0] TIMEOUT       = 16'd1023
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 init_end,
    input  logic                 rd_start,
    input  logic [IMG_SEL_W-1:0] img_sel,
    input  logic                 rd_busy,
    output logic                 rd_en,
    output logic [31:0]          rd_addr,
    output logic                 rd_active,
    output logic                 rd_done,
    output logic                 rd_err
);

    sd_state_e   state_q, state_d;
    logic [15:0] sec_cnt_q, sec_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic        busy_seen_q, busy_seen_d;
    logic        rd_en_q, rd_en_d;
    logic        rd_active_q, rd_active_d;
    logic        rd_done_q, rd_done_d;
    logic        rd_err_q, rd_err_d;
    logic        busy_rise, busy_fall;

    sig_edge_det u_busy_edge (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .sig_in    (rd_busy),
        .rise      (busy_rise),
        .fall      (busy_fall)
    );

    always_comb begin
        state_d     = state_q;
        sec_cnt_d   = sec_cnt_q;
        to_cnt_d    = to_cnt_q;
        rd_addr_d   = rd_addr_q;
        busy_seen_d = busy_seen_q;
        rd_en_d     = 1'b0;
        rd_active_d = rd_active_q;
        rd_done_d   = 1'b0;
        rd_err_d    = 1'b0;

        if (state_q != ST_IDLE && !init_end) begin
            // Losing the card outranks every other transition.
            state_d     = ST_IDLE;
            rd_active_d = 1'b0;
            rd_err_d    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (init_end && rd_start) begin
                        state_d     = ST_READ;
                        rd_addr_d   = img_base(IMG_SEC_ADDR0, SEC_NUM, 32'(img_sel));
                        sec_cnt_d   = 16'd0;
                        rd_en_d     = 1'b1;
                        rd_active_d = 1'b1;
                    end
                end
                ST_READ: begin
                    state_d     = ST_WAIT;
                    busy_seen_d = 1'b0;
                    to_cnt_d    = 16'd0;
                end
                ST_WAIT: begin
                    if (busy_rise || rd_busy) begin
                        busy_seen_d = 1'b1;
                    end
                    if (busy_fall && busy_seen_q) begin
                        if (sec_cnt_q == SEC_NUM - 16'd1) begin
                            state_d     = ST_IDLE;
                            rd_active_d = 1'b0;
                            rd_done_d   = 1'b1;
                        end else begin
                            state_d   = ST_READ;
                            sec_cnt_d = sec_cnt_q + 16'd1;
                            rd_addr_d = rd_addr_q + 32'd1;
                            rd_en_d   = 1'b1;
                        end
                    end else if (!busy_seen_q && !rd_busy) begin
                        // Engine has not answered this request yet; a stale
                        // busy_fall left over from before it is ignored here.
                        if (to_cnt_q == TIMEOUT) begin
                            state_d     = ST_IDLE;
                            rd_active_d = 1'b0;
                            rd_err_d    = 1'b1;
                        end else begin
                            to_cnt_d = to_cnt_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    rd_active_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            sec_cnt_q   <= 16'd0;
            to_cnt_q    <= 16'd0;
            rd_addr_q   <= IMG_SEC_ADDR0;
            busy_seen_q <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_active_q <= 1'b0;
            rd_done_q   <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_cnt_q   <= sec_cnt_d;
            to_cnt_q    <= to_cnt_d;
            rd_addr_q   <= rd_addr_d;
            busy_seen_q <= busy_seen_d;
            rd_en_q     <= rd_en_d;
            rd_active_q <= rd_active_d;
            rd_done_q   <= rd_done_d;
            rd_err_q    <= rd_err_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign rd_active = rd_active_q;
    assign rd_done   = rd_done_q;
    assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_sd_img_rd_ctrl.sv
// Scoreboard bench: stimulus pushes expected events, negedge monitors pop and compare.
// dut_a: SEC_NUM=4, base 0, TIMEOUT=20.  dut_b: SEC_NUM=1200, base 100, TIMEOUT=1023.
module tb_sd_img_rd_ctrl;

    localparam int K_RD   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        bit          gap;      // must follow a busy fall by exactly one cycle
        int          abs_cyc;  // required cycle, -1 = don't care
        int          rel_en;   // required distance from last rd_en, 0 = don't care
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- DUT A ----------------
    logic        init_end_a = 1'b1, rd_start_a = 1'b0, rd_busy_a;
    logic [1:0]  img_sel_a = 2'd0;
    logic        rd_en_a, rd_active_a, rd_done_a, rd_err_a;
    logic [31:0] rd_addr_a;

    sd_img_rd_ctrl #(.IMG_SEC_ADDR0(32'd0), .SEC_NUM(16'd4), .IMG_SEL_W(2), .TIMEOUT(16'd20)) dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end_a), .rd_start(rd_start_a),
        .img_sel(img_sel_a), .rd_busy(rd_busy_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
        .rd_active(rd_active_a), .rd_done(rd_done_a), .rd_err(rd_err_a)
    );

    // Engine model A: busy for 10 cycles starting the edge after each rd_en.
    bit eng_on_a = 1'b1;
    int busy_left_a = 0;
    int fall_edge_a = -100;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_busy_a   <= 1'b0;
            busy_left_a <= 0;
        end else if (rd_en_a && eng_on_a) begin
            rd_busy_a   <= 1'b1;
            busy_left_a <= 10;
        end else if (busy_left_a == 1) begin
            rd_busy_a   <= 1'b0;
            busy_left_a <= 0;
            fall_edge_a <= cyc + 1;
        end else if (busy_left_a > 1) begin
            busy_left_a <= busy_left_a - 1;
        end
    end

    exp_t exp_a[$];
    exp_t ea;
    int   kind_a;
    int   last_en_a = 0;
    int   en_cnt_a = 0;

    always @(negedge sys_clk) begin
        if (sys_rst_n && (rd_en_a || rd_done_a || rd_err_a)) begin
            chk("a_evt_exclusive", int'(rd_en_a) + int'(rd_done_a) + int'(rd_err_a), 1);
            kind_a = rd_en_a ? K_RD : (rd_done_a ? K_DONE : K_ERR);
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: got event kind %0d addr %0d, expected none (cyc %0d)",
                         kind_a, rd_addr_a, cyc);
            end else begin
                ea = exp_a.pop_front();
                chk("a_kind", kind_a, ea.kind);
                chk("a_addr", rd_addr_a, ea.addr);
                chk("a_active", rd_active_a, (ea.kind == K_RD) ? 1 : 0);
                if (ea.gap)          chk("a_gap_after_fall", cyc, fall_edge_a + 1);
                if (ea.abs_cyc >= 0) chk("a_event_cycle", cyc, ea.abs_cyc);
                if (ea.rel_en > 0)   chk("a_timeout_cycle", cyc, last_en_a + ea.rel_en);
                if (kind_a == K_RD) begin
                    last_en_a = cyc;
                    en_cnt_a++;
                end
            end
            $display("[A] cyc=%0d kind=%0d addr=%0d active=%0d", cyc, kind_a, rd_addr_a, rd_active_a);
        end
    end

    function automatic void push_a(input int kind, input logic [31:0] addr, input bit gap,
                                   input int abs_cyc, input int rel_en);
        exp_t e;
        e.kind = kind; e.addr = addr; e.gap = gap; e.abs_cyc = abs_cyc; e.rel_en = rel_en;
        exp_a.push_back(e);
    endfunction

    task automatic start_a(input logic [1:0] sel, input bit full);
        logic [31:0] base;
        base = 32'(sel) * 32'd4;
        if (full) begin
            for (int i = 0; i < 4; i++) push_a(K_RD, base + 32'(i), (i != 0), -1, 0);
            push_a(K_DONE, base + 32'd3, 1'b1, -1, 0);
        end
        @(negedge sys_clk);
        rd_start_a = 1'b1;
        img_sel_a  = sel;
        @(negedge sys_clk);
        rd_start_a = 1'b0;
    endtask

    task automatic wait_a(input int budget, input string tag);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || rd_active_a) && n < budget) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        chk(tag, exp_a.size(), 0);
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic wait_en_a(input int target, input int budget);
        int n;
        n = 0;
        while (en_cnt_a < target && n < budget) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        chk("a_wait_rd_en_count", en_cnt_a, target);
    endtask

    // ---------------- DUT B ----------------
    logic        init_end_b = 1'b1, rd_start_b = 1'b0, rd_busy_b;
    logic [1:0]  img_sel_b = 2'd0;
    logic        rd_en_b, rd_active_b, rd_done_b, rd_err_b;
    logic [31:0] rd_addr_b;

    sd_img_rd_ctrl #(.IMG_SEC_ADDR0(32'd100), .SEC_NUM(16'd1200), .IMG_SEL_W(2), .TIMEOUT(16'd1023)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end_b), .rd_start(rd_start_b),
        .img_sel(img_sel_b), .rd_busy(rd_busy_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_active(rd_active_b), .rd_done(rd_done_b), .rd_err(rd_err_b)
    );

    int busy_left_b = 0;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_busy_b   <= 1'b0;
            busy_left_b <= 0;
        end else if (rd_en_b) begin
            rd_busy_b   <= 1'b1;
            busy_left_b <= 2;
        end else if (busy_left_b == 1) begin
            rd_busy_b   <= 1'b0;
            busy_left_b <= 0;
        end else if (busy_left_b > 1) begin
            busy_left_b <= busy_left_b - 1;
        end
    end

    exp_t        exp_b[$];
    exp_t        eb;
    int          en_cnt_b = 0;
    logic [31:0] first_b = 32'd0;
    logic [31:0] last_b = 32'd0;

    always @(negedge sys_clk) begin
        if (sys_rst_n && (rd_en_b || rd_done_b || rd_err_b)) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got en=%0d done=%0d err=%0d addr %0d, expected none",
                         rd_en_b, rd_done_b, rd_err_b, rd_addr_b);
            end else begin
                eb = exp_b.pop_front();
                chk("b_kind", rd_en_b ? K_RD : (rd_done_b ? K_DONE : K_ERR), eb.kind);
                chk("b_addr", rd_addr_b, eb.addr);
            end
            if (rd_en_b) begin
                if (en_cnt_b == 0) first_b = rd_addr_b;
                last_b = rd_addr_b;
                en_cnt_b++;
            end
            if (rd_done_b || rd_err_b)
                $display("[B] cyc=%0d image end done=%0d err=%0d pulses=%0d first=%0d last=%0d",
                         cyc, rd_done_b, rd_err_b, en_cnt_b, first_b, last_b);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        exp_t e;
        int   n;

        repeat (3) @(negedge sys_clk);
        chk("rst_rd_en", rd_en_a, 0);
        chk("rst_rd_addr", rd_addr_a, 0);
        chk("rst_rd_active", rd_active_a, 0);
        chk("rst_rd_done", rd_done_a, 0);
        chk("rst_rd_err", rd_err_a, 0);
        chk("rst_b_rd_addr", rd_addr_b, 100);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // 1: four sectors from slot 0
        start_a(2'd0, 1'b1);
        wait_a(400, "t1_drain");
        chk("t1_addr_hold", rd_addr_a, 3);

        // 2: slot 2 of a 1200-sector layout at base 100 -> 2500..3699
        for (int i = 0; i < 1200; i++) begin
            e.kind = K_RD; e.addr = 32'd2500 + 32'(i); e.gap = 1'b0; e.abs_cyc = -1; e.rel_en = 0;
            exp_b.push_back(e);
        end
        e.kind = K_DONE; e.addr = 32'd3699;
        exp_b.push_back(e);
        @(negedge sys_clk);
        rd_start_b = 1'b1;
        img_sel_b  = 2'd2;
        @(negedge sys_clk);
        rd_start_b = 1'b0;
        n = 0;
        while ((exp_b.size() != 0 || rd_active_b) && n < 10000) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        chk("t2_drain", exp_b.size(), 0);
        chk("t2_pulses", en_cnt_b, 1200);
        chk("t2_first", first_b, 2500);
        chk("t2_last", last_b, 3699);
        chk("t2_addr_hold", rd_addr_b, 3699);

        // 3: rd_start without init_end is ignored
        init_end_a = 1'b0;
        start_a(2'd1, 1'b0);
        repeat (30) @(negedge sys_clk);
        chk("t3_idle_active", rd_active_a, 0);
        init_end_a = 1'b1;
        repeat (2) @(negedge sys_clk);

        // 4: second rd_start mid-transfer is ignored
        n = en_cnt_a;
        start_a(2'd1, 1'b1);
        wait_en_a(n + 2, 100);
        rd_start_a = 1'b1;
        img_sel_a  = 2'd3;
        repeat (14) @(negedge sys_clk);
        rd_start_a = 1'b0;
        wait_a(400, "t4_drain");
        chk("t4_addr_hold", rd_addr_a, 7);

        // 5: engine silent -> timeout abort 22 cycles after rd_en
        eng_on_a = 1'b0;
        push_a(K_RD, 32'd12, 1'b0, -1, 0);
        push_a(K_ERR, 32'd12, 1'b0, -1, 22);
        start_a(2'd3, 1'b0);
        wait_a(100, "t5_drain");
        chk("t5_active", rd_active_a, 0);
        repeat (30) @(negedge sys_clk);
        eng_on_a = 1'b1;

        // 6: init_end lost in the third sector's WAIT, then restart at base
        n = en_cnt_a;
        push_a(K_RD, 32'd0, 1'b0, -1, 0);
        push_a(K_RD, 32'd1, 1'b1, -1, 0);
        push_a(K_RD, 32'd2, 1'b1, -1, 0);
        start_a(2'd0, 1'b0);
        wait_en_a(n + 3, 200);
        repeat (3) @(negedge sys_clk);
        push_a(K_ERR, 32'd2, 1'b0, cyc + 1, 0);
        init_end_a = 1'b0;
        wait_a(50, "t6_abort_drain");
        repeat (20) @(negedge sys_clk);
        init_end_a = 1'b1;
        repeat (2) @(negedge sys_clk);
        start_a(2'd0, 1'b1);
        wait_a(400, "t6_restart_drain");

        // 7: asynchronous reset mid-transfer, then fresh start
        n = en_cnt_a;
        start_a(2'd2, 1'b1);
        wait_en_a(n + 2, 100);
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("t7_rst_rd_en", rd_en_a, 0);
        chk("t7_rst_rd_addr", rd_addr_a, 0);
        chk("t7_rst_rd_active", rd_active_a, 0);
        chk("t7_rst_rd_done", rd_done_a, 0);
        chk("t7_rst_rd_err", rd_err_a, 0);
        exp_a.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        start_a(2'd1, 1'b1);
        wait_a(400, "t7_restart_drain");

        chk("final_a_queue", exp_a.size(), 0);
        chk("final_b_queue", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

endmodule
